// File: rtl/ripple_accumulator.sv
// ripple_accumulator: streaming packet accumulator behind the N-bit adder datapath.
// Sums unsigned operand beats into an ACC_W-bit total and presents the total,
// a sticky carry-out flag and a saturating beat count once the packet ends.
module ripple_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_out_sum;
  logic               r_out_ovf;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic               w_fire;
  logic [ACC_W-1:0]   w_opnd;
  logic [ACC_W:0]     w_add;
  logic [ACC_W-1:0]   w_sum;
  logic               w_ovf;
  logic [CNT_W-1:0]   w_cnt;

  assign w_fire = in_valid && r_in_ready;
  assign w_opnd = ACC_W'(in_data);

  // Next running total, carry-out accumulation and saturating beat count.
  always_comb begin
    w_add = {1'b0, r_acc} + {1'b0, w_opnd};
    w_sum = w_add[ACC_W-1:0];
    w_ovf = r_ovf | w_add[ACC_W];
    w_cnt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  end

  // Packet FSM with registered handshake/status outputs. in_ready is a register
  // cleared by reset so it first rises on the clock edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_fire) begin
            r_acc  <= w_opnd;
            r_ovf  <= 1'b0;
            r_cnt  <= CNT_W'(1);
            r_busy <= 1'b1;
            if (in_last) begin
              r_state     <= S_HOLD;
              r_out_sum   <= w_opnd;
              r_out_ovf   <= 1'b0;
              r_out_cnt   <= CNT_W'(1);
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_fire) begin
            r_acc <= w_sum;
            r_ovf <= w_ovf;
            r_cnt <= w_cnt;
            if (in_last) begin
              r_state     <= S_HOLD;
              r_out_sum   <= w_sum;
              r_out_ovf   <= w_ovf;
              r_out_cnt   <= w_cnt;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_cnt   = r_out_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ripple_accumulator.sv
// Directed bench for ripple_accumulator (N=4, ACC_W=8, CNT_W=4).
module tb_ripple_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic [3:0] out_cnt;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ripple_accumulator #(.N(4), .ACC_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait on in_ready).
  task automatic send_beat(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'd0;
  endtask

  task automatic check_result(input string tag, input int sum, input int ovf, input int cnt);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sum"},   32'(out_sum),   32'(sum));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    chk({tag, "_cnt"},   32'(out_cnt),   32'(cnt));
    chk({tag, "_rdy"},   32'(in_ready),  0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready),  0);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_sum",   32'(out_sum),   0);
    chk("rst_cnt",   32'(out_cnt),   0);
    chk("rst_ovf",   32'(out_ovf),   0);
    rst_n = 1'b1;
    chk("rel_ready_pre", 32'(in_ready), 0);
    step();
    chk("rel_ready", 32'(in_ready), 1);

    // 1: 15,15,15,15
    send_beat(4'd15, 1'b0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_noval", 32'(out_valid), 0);
    send_beat(4'd15, 1'b0);
    send_beat(4'd15, 1'b0);
    send_beat(4'd15, 1'b1);
    check_result("t1", 60, 0, 4);
    step();
    chk("t1_drop", 32'(out_valid), 0);
    chk("t1_keep", 32'(out_sum), 60);
    chk("t1_rdy",  32'(in_ready), 1);
    chk("t1_idle", 32'(busy), 0);

    // 2: 18 beats of 15 -> wrap and saturate
    for (int i = 0; i < 18; i++) send_beat(4'd15, (i == 17) ? 1'b1 : 1'b0);
    check_result("t2", 14, 1, 15);
    step();

    // 3: single beat from IDLE
    send_beat(4'd7, 1'b1);
    check_result("t3", 7, 0, 1);
    step();
    chk("t3_drop", 32'(out_valid), 0);

    // 4: back-pressure; a last beat offered during HOLD must be ignored
    out_ready = 1'b0;
    send_beat(4'd3, 1'b0);
    send_beat(4'd5, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", 32'(out_valid), 1);
      chk("t4_sum",   32'(out_sum),   8);
      chk("t4_cnt",   32'(out_cnt),   2);
      chk("t4_rdy",   32'(in_ready),  0);
      step();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b1;
    chk("t4_hs_valid", 32'(out_valid), 1);
    chk("t4_hs_rdy",   32'(in_ready),  0);
    step();
    chk("t4_idle_valid", 32'(out_valid), 0);
    chk("t4_idle_busy",  32'(busy),      0);
    chk("t4_idle_rdy",   32'(in_ready),  1);
    chk("t4_idle_sum",   32'(out_sum),   8);

    // 5: reset mid-packet
    send_beat(4'd9, 1'b0);
    send_beat(4'd9, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_sum",   32'(out_sum),   0);
    chk("t5_rst_cnt",   32'(out_cnt),   0);
    chk("t5_rst_ovf",   32'(out_ovf),   0);
    chk("t5_rst_busy",  32'(busy),      0);
    chk("t5_rst_rdy",   32'(in_ready),  0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t5_rel_valid", 32'(out_valid), 0);
    chk("t5_rel_rdy",   32'(in_ready),  1);
    send_beat(4'd2, 1'b1);
    check_result("t5", 2, 0, 1);
    step();

    // 6: gaps in in_valid during ACCUM
    send_beat(4'd1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("t6_gap_busy",  32'(busy),      1);
    chk("t6_gap_valid", 32'(out_valid), 0);
    chk("t6_gap_rdy",   32'(in_ready),  1);
    send_beat(4'd2, 1'b0);
    step();
    send_beat(4'd4, 1'b1);
    check_result("t6", 7, 0, 3);
    step();
    chk("t6_drop", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
